data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words; power of two, at most 2^(ADDR_W-2).
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port Req  in  1  access request.
REQ-006 SHALL have port Ready  out  1  controller idle; a request is accepted when Req && Ready.
REQ-007 SHALL have port WE  in  1  1 = store, 0 = load.
REQ-008 SHALL have port DAddr  in  ADDR_W  byte address.
REQ-009 SHALL have port DataIn  in  32  store data, right-justified.
REQ-010 SHALL have port Load  in  3  load type: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; 101-111 behave as LW.
REQ-011 SHALL have port Store  in  2  store type: 00 SB, 01 SH, 10 SW; 11 behaves as SW.
REQ-012 SHALL have port RValid  out  1  one-cycle completion pulse for every accepted access.
REQ-013 SHALL have port DataOut  out  32  load result, valid while RValid = 1; 0 for stores.
REQ-014 SHALL have port AddrErr  out  1  one-cycle pulse with RValid when the access faulted.

Function
REQ-015 SHALL capture WE, DAddr, DataIn, Load and Store on the accepting edge; later input changes SHALL NOT affect the access.
REQ-016 SHALL implement FSM states IDLE, ACC1, ACC2, RESP; Ready = 1 only in IDLE.
REQ-017 SHALL move IDLE->ACC1 on accept, ACC1->ACC2 when the access crosses a word boundary and split is enabled, otherwise ACC1->RESP, ACC2->RESP, and RESP->IDLE.
REQ-018 SHALL assert RValid in RESP only; an aligned access has 2-cycle latency (accept edge to RValid); a split access has 3-cycle latency.
REQ-019 SHALL store little-endian: byte at DAddr goes to bits [7:0], DAddr+1 to [15:8], and so on.
REQ-020 SHALL sign-extend LB/LH from bit 7/15 and zero-extend LBU/LHU.
REQ-021 SHALL write only the addressed byte lanes; untouched bytes in the same word SHALL be preserved.
REQ-022 SHALL treat the word index as (DAddr>>2) modulo DEPTH_WORDS, so addresses wrap and out-of-range addresses never fault.
REQ-023 SHALL classify an access as crossing when (DAddr[1:0] + size - 1) > 3; byte accesses never cross.
REQ-024 SHALL compute a crossing access's second word as the next word index, wrapping from DEPTH_WORDS-1 to 0.
REQ-025 SHALL hold DataOut at 0 whenever RValid = 0.

Reset
REQ-026 SHALL on Reset force the state to IDLE and Ready = 1, and drive RValid = 0, AddrErr = 0 and DataOut = 0 on the next edge.
REQ-027 SHALL NOT clear memory contents on Reset.
REQ-028 SHALL let a Reset asserted in ACC1 or ACC2 abort the access with no RValid; the ACC1 half of a split store already written SHALL remain, and the ACC2 half SHALL NOT be written.
REQ-029 SHALL give Reset priority over Req in the same cycle.

Configuration
REQ-030 SHALL, with macro DATAMEM_MISALIGN_EN defined, execute crossing accesses as two word accesses (ACC1 low word, ACC2 high word) with AddrErr = 0.
REQ-031 SHALL, without DATAMEM_MISALIGN_EN, never enter ACC2: a crossing load returns DataOut = 0 and a crossing store writes nothing, both with AddrErr = 1 at 2-cycle latency.
REQ-032 SHALL handle non-crossing misaligned accesses (e.g. LH at offset 1) identically in both configurations.

Structure
REQ-033 SHALL place the Load/Store encodings, the FSM state encoding and the access-size function in shared package datamem_pkg.
REQ-034 SHALL instantiate one sub-module, dmem_ram: a DEPTH_WORDS x 32 synchronous RAM with one read port and one write port, 4-bit byte enable and read-first behaviour.

Verification
REQ-035 SHALL be verified by: SW 0x8899AABB @0x10, then LB @0x10 -> DataOut 0xFFFFFFBB and LBU @0x11 -> 0x000000AA, each with RValid 2 cycles after accept.
REQ-036 SHALL be verified by: SW 0x11223344 @0x20, SB 0xEE @0x22, then LW @0x20 -> 0x11EE3344.
REQ-037 SHALL be verified by: with DATAMEM_MISALIGN_EN, SW 0xA1B2C3D4 @0x0E, then LW @0x0E -> 0xA1B2C3D4 at 3-cycle latency, word 0x0C bytes [31:16] = C3D4 and word 0x10 bytes [15:0] = A1B2.
REQ-038 SHALL be verified by: without DATAMEM_MISALIGN_EN, the REQ-037 store -> AddrErr = 1, and memory at 0x0C/0x10 unchanged.
REQ-039 SHALL be verified by: DEPTH_WORDS = 1024 and SW 0x55 @0x1000 -> LW @0x0 returns 0x00000055 (wrap).
REQ-040 SHALL be verified by: Reset in ACC2 of a split store -> no RValid, Ready = 1 next cycle, only the first word modified.

Source files
------------

// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - load/store encodings, FSM states and access-size helpers
package datamem_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LBU = 3'b001,
    LD_LH  = 3'b010,
    LD_LHU = 3'b011,
    LD_LW  = 3'b100
  } load_t;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } store_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC1 = 2'b01,
    ACC2 = 2'b10,
    RESP = 2'b11
  } state_t;

  // Size in bytes; unlisted load/store codes fall through to word size.
  function automatic logic [2:0] access_size(input logic we, input logic [2:0] load,
                                             input logic [1:0] store);
    logic [2:0] sz;
    if (we) begin
      case (store)
        ST_SB:   sz = 3'd1;
        ST_SH:   sz = 3'd2;
        default: sz = 3'd4;
      endcase
    end else begin
      case (load)
        LD_LB, LD_LBU: sz = 3'd1;
        LD_LH, LD_LHU: sz = 3'd2;
        default:       sz = 3'd4;
      endcase
    end
    return sz;
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] sz);
    case (sz)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // offset + size - 1 > 3, rearranged to stay unsigned
  function automatic logic crosses_word(input logic [1:0] off, input logic [2:0] sz);
    return ({2'b00, off} + {1'b0, sz}) > 4'd4;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] load, input logic [31:0] raw);
    case (load)
      LD_LB:   return {{24{raw[7]}}, raw[7:0]};
      LD_LBU:  return {24'b0, raw[7:0]};
      LD_LH:   return {{16{raw[15]}}, raw[15:0]};
      LD_LHU:  return {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - DEPTH_WORDS x 32 synchronous RAM, byte-enabled write, read-first read
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte/half/word load-store controller over a word RAM
// DATAMEM_MISALIGN_EN: word-crossing accesses run as two word accesses instead of faulting.
module data_mem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Req,
  output logic              Ready,
  input  logic              WE,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DataIn,
  input  logic [2:0]        Load,
  input  logic [1:0]        Store,
  output logic              RValid,
  output logic [31:0]       DataOut,
  output logic              AddrErr
);
  import datamem_pkg::*;

  localparam int IDX_W = $clog2(DEPTH_WORDS);
`ifdef DATAMEM_MISALIGN_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             we_q, cross_q;
  logic [1:0]       off_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q, lo_q;
  logic [2:0]       load_q, size_q;

  logic             accept, split, fault;
  logic             ram_we;
  logic [3:0]       ram_be;
  logic [IDX_W-1:0] ram_addr;
  logic [31:0]      ram_wdata, ram_rdata;
  logic [63:0]      st_wide, ld_wide;
  logic [7:0]       be_wide;
  logic             unused_bits;

  assign accept      = Req && (state_q == IDLE) && !Reset;
  assign split       = cross_q && SPLIT_EN;
  assign fault       = cross_q && !SPLIT_EN;
  assign unused_bits = ^{DAddr, ld_wide[63:32]};

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Req) state_d = ACC1;
      ACC1:    state_d = split ? ACC2 : RESP;
      ACC2:    state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at accept; lo_q holds the first word of a split load.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= WE;
      off_q   <= DAddr[1:0];
      idx_q   <= DAddr[IDX_W+1:2];
      data_q  <= DataIn;
      load_q  <= Load;
      size_q  <= access_size(WE, Load, Store);
      cross_q <= crosses_word(DAddr[1:0], access_size(WE, Load, Store));
    end
    if (state_q == ACC2) lo_q <= ram_rdata;
  end

  // Two-word little-endian window: low half is the addressed word, high half the next one.
  assign st_wide = {32'b0, data_q} << {off_q, 3'b000};
  assign be_wide = {4'b0, size_mask(size_q)} << off_q;
  assign ld_wide = {ram_rdata, split ? lo_q : ram_rdata} >> {off_q, 3'b000};

  always_comb begin
    Ready     = (state_q == IDLE);
    RValid    = (state_q == RESP);
    AddrErr   = RValid && fault;
    DataOut   = (RValid && !we_q && !fault) ? extend_load(load_q, ld_wide[31:0]) : 32'b0;
    ram_we    = 1'b0;
    ram_be    = be_wide[3:0];
    ram_addr  = idx_q;
    ram_wdata = st_wide[31:0];
    if (state_q == ACC2) begin
      ram_addr  = idx_q + IDX_W'(1);
      ram_be    = be_wide[7:4];
      ram_wdata = st_wide[63:32];
    end
    // A reset landing on the write edge cancels that word's write.
    if (state_q == ACC1 || state_q == ACC2) ram_we = we_q && !fault && !Reset;
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .be   (ram_be),
    .waddr(ram_addr),
    .wdata(ram_wdata),
    .raddr(ram_addr),
    .rdata(ram_rdata)
  );

endmodule
